// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter: FSM states,
// requester (owner) identifiers and the default response timeout.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   localparam int unsigned TIMEOUT_DEFAULT = 16;

   function automatic owner_t other_owner(input owner_t o);
      return (o == OWN_IF) ? OWN_D : OWN_IF;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single memory port with one
// outstanding transaction, round-robin on ties and a bounded response wait.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic              if_err,
   output logic [DATA_W-1:0] if_rdata,

   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic              d_err,
   output logic [DATA_W-1:0] d_rdata,

   output logic              m_req,
   output logic              m_we,
   output logic [3:0]        m_be,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_gnt,
   input  logic              m_rvalid,
   input  logic [DATA_W-1:0] m_rdata
);

   localparam int unsigned      CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   state_t            state;
   owner_t            owner;
   owner_t            last_owner;
   owner_t            pick;
   logic              grant;
   logic              resp;
   logic              resp_err;
   logic [DATA_W-1:0] resp_data;
   logic [CNT_W-1:0]  cnt;

   // Arbitration is only evaluated in IDLE; gating with rst keeps the
   // combinational grant low while reset is held.
   always_comb begin
      grant = 1'b0;
      pick  = OWN_IF;
      if (!rst && state == S_IDLE) begin
         if (if_req && d_req) begin
            grant = 1'b1;
            pick  = other_owner(last_owner);
         end else if (if_req) begin
            grant = 1'b1;
            pick  = OWN_IF;
         end else if (d_req) begin
            grant = 1'b1;
            pick  = OWN_D;
         end
      end
   end

   // A real response wins over a timeout that lands on the same cycle.
   always_comb begin
      resp      = !rst && (state == S_WAIT) && (m_rvalid || (cnt == CNT_MAX));
      resp_err  = !m_rvalid;
      resp_data = m_rvalid ? m_rdata : '0;
   end

   assign if_gnt    = grant && (pick == OWN_IF);
   assign d_gnt     = grant && (pick == OWN_D);

   assign if_rvalid = resp && (owner == OWN_IF);
   assign if_err    = if_rvalid && resp_err;
   assign if_rdata  = if_rvalid ? resp_data : '0;

   assign d_rvalid  = resp && (owner == OWN_D);
   assign d_err     = d_rvalid && resp_err;
   assign d_rdata   = d_rvalid ? resp_data : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         owner      <= OWN_IF;
         last_owner <= OWN_IF;
         cnt        <= '0;
         m_req      <= 1'b0;
         m_we       <= 1'b0;
         m_be       <= '0;
         m_addr     <= '0;
         m_wdata    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant) begin
                  owner      <= pick;
                  last_owner <= pick;
                  m_req      <= 1'b1;
                  state      <= S_REQ;
                  if (pick == OWN_IF) begin
                     m_we    <= 1'b0;
                     m_be    <= '1;
                     m_addr  <= if_addr;
                     m_wdata <= '0;
                  end else begin
                     m_we    <= d_we;
                     m_be    <= d_be;
                     m_addr  <= d_addr;
                     m_wdata <= d_wdata;
                  end
               end
            end
            S_REQ: begin
               if (m_gnt) begin
                  m_req <= 1'b0;
                  cnt   <= '0;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (m_rvalid || (cnt == CNT_MAX)) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               m_req <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt, if_rvalid, if_err;
   logic [DW-1:0] if_rdata;
   logic          d_req = 1'b0, d_we = 1'b0;
   logic [3:0]    d_be = '0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_gnt, d_rvalid, d_err;
   logic [DW-1:0] d_rdata;
   logic          m_req, m_we;
   logic [3:0]    m_be;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_gnt = 1'b0, m_rvalid = 1'b0;
   logic [DW-1:0] m_rdata = '0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_err(if_err), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   // Transaction-level model: a pending transaction, who owns it, when memory
   // accepted it, and what was captured at grant time.
   bit            busy = 0, accepted = 0, own_d = 0, last_d = 0;
   int unsigned   cyc = 0, acc_cyc = 0;
   logic          cap_we;
   logic [3:0]    cap_be;
   logic [AW-1:0] cap_addr;
   logic [DW-1:0] cap_wdata;

   logic          s_if_gnt, s_if_rvalid, s_if_err, s_d_gnt, s_d_rvalid, s_d_err;
   logic          s_m_req, s_m_we;
   logic [3:0]    s_m_be;
   logic [DW-1:0] s_if_rdata, s_d_rdata, s_m_wdata;
   logic [AW-1:0] s_m_addr;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Called at a negedge with inputs already driven; checks, advances one clock.
   task automatic cycle();
      bit            e_if_gnt, e_d_gnt, resp, e_err;
      logic [DW-1:0] e_data;
      int            age;
      e_if_gnt = 0; e_d_gnt = 0; resp = 0; e_err = 0; e_data = '0;
      #1;
      s_if_gnt = if_gnt; s_if_rvalid = if_rvalid; s_if_err = if_err; s_if_rdata = if_rdata;
      s_d_gnt = d_gnt; s_d_rvalid = d_rvalid; s_d_err = d_err; s_d_rdata = d_rdata;
      s_m_req = m_req; s_m_we = m_we; s_m_be = m_be; s_m_addr = m_addr; s_m_wdata = m_wdata;
      if (rst) begin
         chk("rst_outputs", {s_if_gnt, s_if_rvalid, s_if_err, s_d_gnt, s_d_rvalid, s_d_err, s_m_req, s_m_we}, 64'd0);
         chk("rst_rdata", {s_if_rdata, s_d_rdata}, 64'd0);
         chk("rst_m_fields", {s_m_be, s_m_addr}, 64'd0);
         chk("rst_m_wdata", s_m_wdata, 64'd0);
      end else begin
         if (!busy) begin
            if (if_req && d_req) begin
               e_d_gnt = !last_d; e_if_gnt = last_d;
            end else begin
               e_if_gnt = if_req; e_d_gnt = d_req;
            end
         end else if (accepted) begin
            age    = int'(cyc) - int'(acc_cyc) - 1;
            resp   = m_rvalid || (age == int'(TO));
            e_err  = !m_rvalid;
            e_data = m_rvalid ? m_rdata : '0;
         end
         chk("if_gnt", s_if_gnt, e_if_gnt);
         chk("d_gnt", s_d_gnt, e_d_gnt);
         chk("if_resp", {s_if_rvalid, s_if_err, s_if_rdata},
             {resp && !own_d, resp && !own_d && e_err, (resp && !own_d) ? e_data : '0});
         chk("d_resp", {s_d_rvalid, s_d_err, s_d_rdata},
             {resp && own_d, resp && own_d && e_err, (resp && own_d) ? e_data : '0});
         chk("m_req", s_m_req, busy && !accepted);
         if (busy && !accepted) begin
            chk("m_we_be", {s_m_we, s_m_be}, {cap_we, cap_be});
            chk("m_addr", s_m_addr, cap_addr);
            if (own_d) chk("m_wdata", s_m_wdata, cap_wdata);
         end
      end
      @(posedge clk);
      if (rst) begin
         busy = 0; accepted = 0; last_d = 0;
      end else if (!busy) begin
         if (e_if_gnt || e_d_gnt) begin
            busy = 1; accepted = 0; own_d = e_d_gnt; last_d = e_d_gnt;
            if (e_d_gnt) begin
               cap_we = d_we; cap_be = d_be; cap_addr = d_addr; cap_wdata = d_wdata;
            end else begin
               cap_we = 1'b0; cap_be = 4'hF; cap_addr = if_addr; cap_wdata = '0;
            end
         end
      end else if (!accepted) begin
         if (m_gnt) begin accepted = 1; acc_cyc = cyc; end
      end else if (resp) begin
         busy = 0;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bit exp_d [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      int unsigned tix;
      bit quiet;

      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cycle();
      chk("reset_m_req", s_m_req, 1'b0);
      rst = 1'b0;

      // Stray response with nothing requested
      m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
      repeat (2) begin
         cycle();
         chk("spur_rvalid", {s_if_rvalid, s_d_rvalid, s_if_gnt, s_d_gnt}, 4'b0000);
      end
      m_rvalid = 1'b0;

      // Fetch-only minimum-latency transaction
      if_req = 1'b1; if_addr = 32'h0000_0010; m_gnt = 1'b1;
      cycle();
      chk("t29_if_gnt", s_if_gnt, 1'b1);
      if_req = 1'b0;
      cycle();
      chk("t29_m_req", {s_m_req, s_m_we, s_m_be}, 6'b1_0_1111);
      chk("t29_m_addr", s_m_addr, 32'h10);
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_0013;
      cycle();
      chk("t29_if_rvalid", {s_if_rvalid, s_if_err}, 2'b10);
      chk("t29_if_rdata", s_if_rdata, 32'h13);
      m_rvalid = 1'b0;

      // Tie after reset: data first, then alternate
      do_reset();
      if_req = 1'b1; if_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
      m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h55;
      tix = 0;
      repeat (12) begin
         cycle();
         if (s_if_gnt || s_d_gnt) begin
            if (tix < 4) chk("t30_grant_d", s_d_gnt, exp_d[tix]);
            tix++;
         end
         if (s_m_req && tix >= 1 && tix <= 4)
            chk("t30_m_we_be", {s_m_we, s_m_be}, exp_d[tix-1] ? 5'b1_0011 : 5'b0_1111);
      end
      chk("t30_count", tix, 4);
      if_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
      cycle();

      // Backpressure on m_gnt
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300;
      cycle();
      chk("t31_d_gnt", s_d_gnt, 1'b1);
      d_req = 1'b0;
      repeat (5) begin
         cycle();
         chk("t31_hold", {s_m_req, s_d_rvalid, s_if_rvalid}, 3'b100);
         chk("t31_m_addr", s_m_addr, 32'h300);
      end
      m_gnt = 1'b1;
      cycle();
      chk("t31_accept", s_m_req, 1'b1);
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hA5A5;
      cycle();
      chk("t31_resp", {s_d_rvalid, s_d_err, s_d_rdata}, {2'b10, 32'hA5A5});
      m_rvalid = 1'b0;

      // Timeout: response exactly TO cycles into WAIT
      if_req = 1'b1; if_addr = 32'h400; m_gnt = 1'b1;
      cycle();
      if_req = 1'b0;
      cycle();
      m_gnt = 1'b0;
      for (int k = 0; k <= int'(TO); k++) begin
         cycle();
         if (k < int'(TO)) chk("t32_wait", s_if_rvalid, 1'b0);
         else chk("t32_timeout", {s_if_rvalid, s_if_err, s_if_rdata}, {2'b11, 32'h0});
      end
      d_req = 1'b1; d_addr = 32'h404;
      cycle();
      chk("t32_idle_again", s_d_gnt, 1'b1);
      d_req = 1'b0; m_gnt = 1'b1;
      cycle();
      m_gnt = 1'b0; m_rvalid = 1'b1;
      cycle();
      m_rvalid = 1'b0;

      // Reset while waiting, then stray response
      if_req = 1'b1; if_addr = 32'h500; m_gnt = 1'b1;
      cycle();
      if_req = 1'b0;
      cycle();
      m_gnt = 1'b0;
      repeat (2) cycle();
      rst = 1'b1;
      cycle();
      chk("t33_rst_out", {s_if_rvalid, s_d_rvalid, s_m_req, s_m_addr}, 35'd0);
      rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h77;
      repeat (2) begin
         cycle();
         chk("t33_stray", {s_if_rvalid, s_d_rvalid}, 2'b00);
      end
      m_rvalid = 1'b0; if_req = 1'b1; d_req = 1'b1; d_addr = 32'h600;
      cycle();
      chk("t33_tie_d", {s_d_gnt, s_if_gnt}, 2'b10);
      if_req = 1'b0; d_req = 1'b0;

      // Randomized traffic against the model
      quiet = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) quiet = 1;
         if (n % 200 == 40) quiet = 0;
         if (!if_req || s_if_gnt) begin
            if_req  = ($urandom_range(0, 2) == 0);
            if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!d_req || s_d_gnt) begin
            d_req   = ($urandom_range(0, 2) == 0);
            d_we    = $urandom_range(0, 1) == 1;
            d_be    = 4'($urandom);
            d_addr  = $urandom;
            d_wdata = $urandom;
         end
         m_gnt    = ($urandom_range(0, 2) != 0);
         m_rvalid = !quiet && ($urandom_range(0, 3) == 0);
         m_rdata  = $urandom;
         rst      = (n % 731 == 730);
         cycle();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
